lamp_sequence_monitor: RTL

// - Receive end of the 3-bit lamp drive bus (red=3'b100, green=3'b010, yellow=3'b001).
// - Decodes the lamp code, locks onto the legal green->yellow->red->green cycle and

---
 rtl/lamp_sequence_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor: on-line checker for the 3-bit lamp drive bus
// (red=100, green=010, yellow=001). It locks onto the green->yellow->red->green
// cycle, counts completed cycles (red->green) and flags bad codes, out-of-order
// transitions and lamps held too long. All outputs are registered.
// Optional build macro LAMP_MON_ERR_COUNT_EN adds an 8-bit saturating error
// counter output err_cnt.
//
// Handshake: there is no valid/ready flow control. light is sampled on every
// rising clk edge and every output reflects that sample one cycle later.
// The FSM state is visible on the color port (00 SYNC, 01 GRN, 10 YEL, 11 RED).
module lamp_sequence_monitor #(
  parameter int MAX_DWELL = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  input  logic             clr_err,
  output logic [1:0]       color,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic             stuck_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef LAMP_MON_ERR_COUNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] DWELL_SAT = DW'(MAX_DWELL + 1);
  localparam logic [DW-1:0] DWELL_ONE = DW'(1);

  // State encoding doubles as the decoded colour code.
  typedef enum logic [1:0] {
    SYNC = 2'b00,
    GRN  = 2'b01,
    YEL  = 2'b10,
    RED  = 2'b11
  } state_t;

  state_t          state, state_nxt;
  state_t          obs_st, adv_st;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic            code_nxt, seq_nxt, stuck_nxt, inc_cyc, err_any;

  // Decode the observed lamp code and the one legal successor of the current colour.
  always_comb begin
    obs_st = SYNC;
    adv_st = SYNC;
    case (light)
      3'b010:  obs_st = GRN;
      3'b001:  obs_st = YEL;
      3'b100:  obs_st = RED;
      default: obs_st = SYNC;
    endcase
    case (state)
      GRN:     adv_st = YEL;
      YEL:     adv_st = RED;
      RED:     adv_st = GRN;
      default: adv_st = SYNC;
    endcase
  end

  // Next-state, dwell and error pulse logic.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    code_nxt  = 1'b0;
    seq_nxt   = 1'b0;
    stuck_nxt = 1'b0;
    inc_cyc   = 1'b0;
    if (obs_st == SYNC) begin
      // Not one-hot: drop lock and wait for a valid code.
      code_nxt  = 1'b1;
      state_nxt = SYNC;
      dwell_nxt = '0;
    end else if (state == SYNC) begin
      state_nxt = obs_st;
      dwell_nxt = DWELL_ONE;
    end else if (obs_st == state) begin
      // Same colour held: count up, saturate, pulse only when crossing the limit.
      if (dwell != DWELL_SAT) begin
        dwell_nxt = dwell + DWELL_ONE;
        stuck_nxt = (dwell_nxt == DWELL_SAT);
      end
    end else begin
      state_nxt = obs_st;
      dwell_nxt = DWELL_ONE;
      if (obs_st == adv_st) inc_cyc = (state == RED);
      else                  seq_nxt = 1'b1;
    end
  end

  assign err_any = code_nxt | seq_nxt | stuck_nxt;
  assign color   = state;
  assign locked  = (state != SYNC);

  // State, dwell, pulses, sticky flag and cycle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      dwell      <= '0;
      code_err   <= 1'b0;
      seq_err    <= 1'b0;
      stuck_err  <= 1'b0;
      err_sticky <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      code_err  <= code_nxt;
      seq_err   <= seq_nxt;
      stuck_err <= stuck_nxt;
      // A new error outranks a same-cycle clear.
      if (err_any)      err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
      if (inc_cyc) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

`ifdef LAMP_MON_ERR_COUNT_EN
  // Saturating count of cycles with any error; a clear with a same-cycle error loads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (clr_err) begin
      err_cnt <= {7'd0, err_any};
    end else if (err_any && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
